quad_step_decoder: RTL and testbench

Quadrature-encoder front end that drives the 4-bit up/down counter's `en`/`dir` inputs. It synchronises and glitch-filters the two asynchronous encoder channels A and B, then tracks their Gray-code state. Every legal transition produces a one-cycle `step` pulse with a matching `dir`, so `step` wires to `en` and `dir` to `dir` with no glue logic.

---
 rtl/quad_pkg.sv | 27 ++
 rtl/quad_glitch_filter.sv | 53 +++++
 rtl/quad_step_decoder.sv | 135 +++++++++++++
 tb/tb_quad_step_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step decoder.
// Holds the FSM encoding, the Gray-code position constants and the forward-neighbour function.
package quad_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        TRACK = 1'b1
    } qd_state_t;

    localparam logic [1:0] QC_00 = 2'b00;
    localparam logic [1:0] QC_01 = 2'b01;
    localparam logic [1:0] QC_11 = 2'b11;
    localparam logic [1:0] QC_10 = 2'b10;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; reverse is the inverse mapping.
    function automatic logic [1:0] qd_next_fwd(input logic [1:0] code);
        logic [1:0] nxt;
        case (code)
            QC_00:   nxt = QC_01;
            QC_01:   nxt = QC_11;
            QC_11:   nxt = QC_10;
            default: nxt = QC_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: synchroniser chain followed by a consecutive-sample glitch filter.
// The load input lets the parent seed the filtered value straight from the synchroniser.
module quad_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int FILT_W      = 3
) (
    input  logic clk,
    input  logic arst,
    input  logic din,
    input  logic load,
    output logic sync_out,
    output logic dout
);

    localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_W-1:0]      cnt;
    logic                   filt_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // The filtered value only moves once the synchroniser has disagreed with it
    // for FILT_CYCLES consecutive clocks; any agreement restarts the count.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            filt_q <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            filt_q <= sync_out;
            cnt    <= '0;
        end else if (sync_out == filt_q) begin
            cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
            filt_q <= sync_out;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + 1'b1;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: filters both channels and turns Gray-code moves into step/dir/err pulses.
// state | meaning
// PRIME | waiting for sync chains and filters to settle; outputs silent
// TRACK | compare current code with previous each clock and emit step or err
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int FILT_W      = 3
) (
    input  logic clk,
    input  logic arst,
    input  logic enc_a,
    input  logic enc_b,
    output logic step,
    output logic dir,
    output logic err
);

    localparam int            PRIME_LEN  = SYNC_STAGES + FILT_CYCLES;
    localparam int            PW         = (PRIME_LEN > 1) ? $clog2(PRIME_LEN) : 1;
    localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_LEN - 1);

    qd_state_t     state;
    qd_state_t     state_nxt;
    logic [PW-1:0] prime_cnt;
    logic          prime_load;

    logic          sync_a;
    logic          sync_b;
    logic          f_a;
    logic          f_b;
    logic [1:0]    cur;
    logic [1:0]    prev;

    logic          step_nxt;
    logic          dir_nxt;
    logic          err_nxt;

    quad_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES),
        .FILT_W      (FILT_W)
    ) u_filt_a (
        .clk      (clk),
        .arst     (arst),
        .din      (enc_a),
        .load     (prime_load),
        .sync_out (sync_a),
        .dout     (f_a)
    );

    quad_glitch_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES),
        .FILT_W      (FILT_W)
    ) u_filt_b (
        .clk      (clk),
        .arst     (arst),
        .din      (enc_b),
        .load     (prime_load),
        .sync_out (sync_b),
        .dout     (f_b)
    );

    assign cur        = {f_a, f_b};
    assign prime_load = (state == PRIME) && (prime_cnt == PRIME_LAST);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (prime_load) begin
            state_nxt = TRACK;
        end
    end

    // Anything that is neither equal, a neighbour, nor the reverse neighbour is a
    // two-bit jump; dir keeps its last value so the counter sees no false direction.
    always_comb begin
        step_nxt = 1'b0;
        err_nxt  = 1'b0;
        dir_nxt  = dir;
        if (state == TRACK && cur != prev) begin
            if (cur == qd_next_fwd(prev)) begin
                step_nxt = 1'b1;
                dir_nxt  = 1'b1;
            end else if (prev == qd_next_fwd(cur)) begin
                step_nxt = 1'b1;
                dir_nxt  = 1'b0;
            end else begin
                err_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prime_cnt <= '0;
        end else if (state == PRIME && !prime_load) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    // Seeding prev from the synchronisers keeps a parked encoder silent on entry to TRACK.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            prev <= QC_00;
        end else if (prime_load) begin
            prev <= {sync_a, sync_b};
        end else if (state == TRACK) begin
            prev <= cur;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            step <= 1'b0;
            dir  <= 1'b1;
            err  <= 1'b0;
        end else begin
            step <= step_nxt;
            dir  <= dir_nxt;
            err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with a behavioural 4-bit up/down counter on the outputs.
module tb_quad_step_decoder;

    logic clk;
    logic arst;
    logic enc_a;
    logic enc_b;
    logic step;
    logic dir;
    logic err;

    int   errors;
    int   checks;

    logic [3:0] q_model;
    int   n_step;
    int   n_up;
    int   n_dn;
    int   n_errp;
    int   n_both;

    quad_step_decoder #(
        .SYNC_STAGES (2),
        .FILT_CYCLES (4),
        .FILT_W      (3)
    ) dut (
        .clk   (clk),
        .arst  (arst),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .step  (step),
        .dir   (dir),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model and pulse tallies, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (arst) begin
            q_model = 4'd0;
        end else begin
            if (step) begin
                n_step++;
                if (dir) begin
                    n_up++;
                    q_model = q_model + 4'd1;
                end else begin
                    n_dn++;
                    q_model = q_model - 4'd1;
                end
            end
            if (err) n_errp++;
            if (step && err) n_both++;
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_cnt();
        n_step = 0;
        n_up   = 0;
        n_dn   = 0;
        n_errp = 0;
    endtask

    task automatic set_code(input logic [1:0] c);
        enc_a = c[1];
        enc_b = c[0];
    endtask

    logic [1:0] fwd_seq [5];
    logic [1:0] rev_seq [5];

    initial begin
        errors  = 0;
        checks  = 0;
        q_model = 4'd0;
        n_both  = 0;
        clr_cnt();
        fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        rev_seq = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};

        // Reset/prime with encoder parked at 11
        arst = 1'b1;
        set_code(2'b11);
        tick(3);
        check_val("rst_step", step, 0);
        check_val("rst_dir", dir, 1);
        check_val("rst_err", err, 0);
        arst = 1'b0;
        tick(10);
        check_val("prime_step_cnt", n_step, 0);
        check_val("prime_err_cnt", n_errp, 0);
        check_val("prime_dir", dir, 1);
        check_val("prime_q", q_model, 0);

        // Re-prime parked at 00 for the stepping scenarios
        arst = 1'b1;
        set_code(2'b00);
        tick(2);
        arst = 1'b0;
        tick(10);
        clr_cnt();

        // Forward: first transition also measures latency
        set_code(fwd_seq[0]);
        tick(6);
        check_val("lat_early", step, 0);
        tick(1);
        check_val("lat_step", step, 1);
        check_val("lat_dir", dir, 1);
        tick(1);
        check_val("lat_one_cycle", step, 0);
        tick(7);
        for (int i = 1; i < 5; i++) begin
            set_code(fwd_seq[i]);
            tick(10);
        end
        check_val("fwd_up", n_up, 5);
        check_val("fwd_dn", n_dn, 0);
        check_val("fwd_q", q_model, 5);

        // Reverse: 01 -> 00 -> 10 -> 11
        clr_cnt();
        for (int i = 0; i < 3; i++) begin
            set_code(rev_seq[i]);
            tick(10);
        end
        check_val("rev_dn", n_dn, 3);
        check_val("rev_up", n_up, 0);
        check_val("rev_q", q_model, 2);
        check_val("rev_dir_held", dir, 0);
        for (int i = 3; i < 5; i++) begin
            set_code(rev_seq[i]);
            tick(10);
        end
        check_val("rev_q_home", q_model, 0);

        // Glitch reject at 00: a 3-clock pulse on A must vanish
        clr_cnt();
        enc_a = 1'b1;
        tick(3);
        enc_a = 1'b0;
        tick(12);
        check_val("glitch_step", n_step, 0);
        check_val("glitch_err", n_errp, 0);
        check_val("glitch_q", q_model, 0);
        enc_a = 1'b1;
        tick(10);
        check_val("stable_dn", n_dn, 1);
        check_val("stable_q", q_model, 15);
        enc_a = 1'b0;
        tick(10);
        check_val("stable_back_up", n_up, 1);
        check_val("stable_back_q", q_model, 0);

        // Illegal 00 -> 11
        clr_cnt();
        set_code(2'b11);
        tick(10);
        check_val("ill_err", n_errp, 1);
        check_val("ill_step", n_step, 0);
        check_val("ill_q", q_model, 0);
        check_val("ill_dir", dir, 1);
        clr_cnt();
        set_code(2'b10);
        tick(10);
        check_val("ill_resume_up", n_up, 1);
        check_val("ill_resume_q", q_model, 1);

        // Mid-op reset while a reverse step 10 -> 11 is on the output
        set_code(2'b11);
        tick(7);
        check_val("mid_pending", step, 1);
        check_val("mid_pending_dir", dir, 0);
        #1 arst = 1'b1;
        #1;
        check_val("mid_async_step", step, 0);
        check_val("mid_async_dir", dir, 1);
        tick(2);
        arst = 1'b0;
        clr_cnt();
        tick(10);
        check_val("mid_quiet_step", n_step, 0);
        check_val("mid_quiet_err", n_errp, 0);
        check_val("mid_q_reset", q_model, 0);
        set_code(2'b10);
        tick(10);
        check_val("mid_resume_up", n_up, 1);
        check_val("mid_resume_dn", n_dn, 0);
        check_val("mid_resume_q", q_model, 1);

        check_val("step_err_exclusive", n_both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
